// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It alternates between two states:
//   FETCH - requests the word at pc from instruction memory and waits for
//           imemValid. The decoder sees BUBBLE while in this state.
//   HOLD  - presents the captured instruction register (IR) to the decoder
//           and holds it until the decoder asserts PCWrite. On that edge the
//           next pc is loaded, the retired count increments, and the unit
//           returns to FETCH.
//
// Parameters
//   RESET_PC   pc loaded on reset
//   BUBBLE     instruction word shown while no valid instruction is held
//
// Ports
//   clock      sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   PCWrite    decoder request to advance (honoured only in HOLD)
//   PCSrc      next-pc select: 00 pc+4, 01 jump, 10 aluResult, 11 regData
//   aluResult  branch target
//   regData    register-jump target
//   imemRdata  instruction memory read data
//   imemValid  read data valid (sampled only while imemReq=1)
//   imemReq    instruction memory read request (high in FETCH)
//   imemAddr   read address, always equal to pc
//   ins        instruction to the decoder (IR in HOLD, BUBBLE otherwise)
//   pc         address of the current instruction
//   insValid   high exactly in HOLD
//   retired    count of completed instructions (wraps modulo 2^32)
//   alignFault sticky flag, set when an advance targets a misaligned address
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'hFC00_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        PCWrite,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] aluResult,
    input  logic [31:0] regData,
    input  logic [31:0] imemRdata,
    input  logic        imemValid,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        insValid,
    output logic [31:0] retired,
    output logic        alignFault
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic [31:0] retired_reg, retired_next;
    logic        fault_reg, fault_next;

    logic [31:0] pc_plus4;
    logic [31:0] target;

    // State register; reset takes effect immediately, independent of clock,
    // so a fetch pending at reset is simply abandoned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= BUBBLE;
            retired_reg <= 32'd0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            retired_reg <= retired_next;
            fault_reg   <= fault_next;
        end
    end

    // Next-pc candidate. The jump form keeps the 256 MB region of pc+4 and
    // replaces the rest with the word index from the instruction.
    always_comb begin
        pc_plus4 = pc_reg + 32'd4;
        target   = pc_plus4;
        case (PCSrc)
            2'b00:   target = pc_plus4;
            2'b01:   target = {pc_plus4[31:28], ir_reg[25:0], 2'b00};
            2'b10:   target = aluResult;
            default: target = regData;
        endcase
    end

    // Next-state and update logic.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        retired_next = retired_reg;
        fault_next   = fault_reg;

        if (state_reg == FETCH) begin
            // PCWrite/PCSrc are deliberately ignored here: the decoder may
            // assert PCWrite while decoding BUBBLE.
            if (imemValid) begin
                ir_next    = imemRdata;
                state_next = HOLD;
            end
        end else begin
            // imemRdata/imemValid are ignored in HOLD; IR stays put so the
            // decoder can take several cycles over one instruction.
            if (PCWrite) begin
                // Misaligned targets are truncated to a word boundary and
                // flagged rather than trapped.
                pc_next      = {target[31:2], 2'b00};
                fault_next   = fault_reg | (|target[1:0]);
                retired_next = retired_reg + 32'd1;
                state_next   = FETCH;
            end
        end
    end

    // Outputs
    always_comb begin
        imemReq    = (state_reg == FETCH);
        insValid   = (state_reg == HOLD);
        imemAddr   = pc_reg;
        pc         = pc_reg;
        ins        = (state_reg == HOLD) ? ir_reg : BUBBLE;
        retired    = retired_reg;
        alignFault = fault_reg;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 Parameter BUBBLE, default 32'hFC00_0000; instruction word presented while no valid instruction is held. Opcode 6'b111111 decodes to no operation downstream.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 PCWrite  input  1  from decoder; advance to the next instruction; honoured only in HOLD.
REQ-006 PCSrc  input  2  from decoder; next-PC select.
REQ-007 aluResult  input  32  branch target (PCSrc=2'b10).
REQ-008 regData  input  32  register-jump target (PCSrc=2'b11).
REQ-009 imemRdata  input  32  instruction memory read data.
REQ-010 imemValid  input  1  read data valid; sampled only while imemReq=1.
REQ-011 imemReq  output  1  instruction memory read request.
REQ-012 imemAddr  output  32  read address; equals pc.
REQ-013 ins  output  32  instruction to decoder: IR in HOLD, BUBBLE otherwise.
REQ-014 pc  output  32  address of the current instruction.
REQ-015 insValid  output  1  high exactly in HOLD.
REQ-016 retired  output  32  count of completed instructions.
REQ-017 alignFault  output  1  sticky misaligned-target flag.

Function
REQ-018 The state machine has two states, FETCH and HOLD; there is no other state.
REQ-019 In FETCH, the block drives imemReq=1 with imemAddr=pc, holds imemAddr stable, and keeps ins=BUBBLE.
REQ-020 In FETCH, when imemValid=1 at a rising edge, the block sets IR<=imemRdata and state<=HOLD; otherwise it stays in FETCH. Arbitrary wait counts apply, including zero-wait (valid on the first FETCH cycle).
REQ-021 In HOLD, the block drives imemReq=0, holds IR constant, and sets ins=IR. This keeps the instruction stable across multi-cycle (two-round) decoder operations.
REQ-022 In HOLD with PCWrite=0, state, pc and IR are unchanged.
REQ-023 In HOLD with PCWrite=1, at the edge: pc<=next, state<=FETCH, retired<=retired+1. ins shows BUBBLE from the next cycle.
REQ-024 next selection: 00 = pc+4; 01 = {pcPlus4[31:28], IR[25:0], 2'b00}; 10 = aluResult; 11 = regData.
REQ-025 All additions are 32-bit modulo 2^32. pc=32'hFFFF_FFFC with PCSrc=00 wraps to 32'h0000_0000, and retired wraps from 32'hFFFF_FFFF to 0.
REQ-026 If next[1:0]!=2'b00 when advancing, pc is loaded with {next[31:2],2'b00} and alignFault<=1. alignFault stays 1 until reset.
REQ-027 PCWrite and PCSrc are ignored in FETCH. The decoder's PCWrite=1 on BUBBLE has no effect.
REQ-028 imemRdata is ignored whenever state=HOLD or imemValid=0.
REQ-029 Minimum throughput is one instruction per 2 cycles: 1 FETCH cycle plus 1 HOLD cycle.

Reset
REQ-030 reset_n=0 forces the following immediately, independent of clock: state=FETCH, pc=RESET_PC, IR=BUBBLE, retired=0, alignFault=0.
REQ-031 During reset, outputs are imemReq=1, imemAddr=RESET_PC, ins=BUBBLE, insValid=0.
REQ-032 Reset asserted mid-fetch (pending imemValid) abandons that fetch. An imemValid arriving while reset_n=0 is ignored.
REQ-033 After reset_n rises, the first fetch is at RESET_PC on the next edge. No instruction is held or retired.

Verification
REQ-034 Zero-wait memory returning 32'h8C00_0000 at address 0, then PCWrite=1, PCSrc=00 -> ins=8C00_0000 one cycle after valid; pc=4 after advance; retired=1.
REQ-035 Hold with PCWrite=0 for 3 cycles, then PCWrite=1 -> ins stable for all 4 HOLD cycles; single retire; no imemReq during HOLD.
REQ-036 pc=32'h1000_0010, IR=32'h0C00_0040, PCSrc=01 -> pc=32'h1000_0100.
REQ-037 PCSrc=11 with regData=32'h0000_0203 -> pc=32'h0000_0200, alignFault=1 and stays 1 through later fetches.
REQ-038 imemValid delayed 5 cycles -> imemAddr constant, ins=BUBBLE, insValid=0 throughout; HOLD entered on the valid edge.
REQ-039 reset_n pulsed low during cycle 2 of a pending fetch at pc=32'h40, with a late valid -> pc=0, retired=0, late data never reaches ins.
